// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared types and constants for the slave-mode I2S receiver.
//   rx_state_e          : framing state (SYNC, LEFT, RIGHT)
//   SAMPLE_BITS_DEFAULT : default bits kept per channel
//   FRAME_*_SLOT        : half of the frame word holding each channel
//                         (left upper, right lower, matching the playback path)
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_e;

  localparam int unsigned SAMPLE_BITS_DEFAULT = 16;

  // Slot index in units of SAMPLE_BITS: frame[slot*SAMPLE_BITS +: SAMPLE_BITS]
  localparam int unsigned FRAME_LEFT_SLOT  = 1;
  localparam int unsigned FRAME_RIGHT_SLOT = 0;

endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: frame buffer between the I2S deserializer and the processor.
// Build option: I2S_RX_FIFO_EN defined   -> DEPTH-entry circular buffer
//               I2S_RX_FIFO_EN undefined -> single holding register (depth 1)
// Ports:
//   clk_i, rst_ni     : clock, async active-low reset
//   flush_i           : empty the buffer (push ignored that cycle)
//   push_i/push_data_i: write one frame
//   pop_i             : remove head frame when valid_o is high
//   ovf_clr_i         : clear the sticky overflow flag
//   data_o, valid_o   : registered head frame and its valid
//   overflow_o        : sticky, a frame was dropped on a full buffer
module i2s_rx_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          ovf_clr_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          overflow_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2s_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          pop_fire;
  logic          drop;

  assign pop_fire = pop_i & valid_q;

`ifdef I2S_RX_FIFO_EN
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          full, push_acc;

  assign full     = (count_q == (PW + 1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push_acc = push_i & ~flush_i & (~full | pop_fire);
  assign drop     = push_i & ~flush_i & full & ~pop_fire;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_acc, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    // The new head can only be the incoming frame when it is the sole entry.
    data_d  = (push_acc && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      data_d   = data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_acc) mem_q[wr_ptr_q] <= push_data_i;
    end
  end
`else
  assign drop = push_i & ~flush_i & valid_q & ~pop_fire;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else begin
      if (pop_fire) valid_d = 1'b0;
      if (push_i && (!valid_q || pop_fire)) begin
        valid_d = 1'b1;
        data_d  = push_data_i;
      end
    end
  end
`endif

  // A drop in the same cycle as a clear wins, so no event is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: slave-mode I2S capture. Oversamples BCLK/WS/DATA on CLK,
// deserializes stereo frames into {left, right} words and buffers them.
// Build option: I2S_RX_FIFO_EN selects the FIFO_DEPTH-entry buffer, otherwise
// a single holding register is used (see i2s_rx_fifo).
// Ports:
//   CLK, Reset          : MasterCLK, async active-low reset
//   Enable              : receiver on; low flushes buffer and forces SYNC
//   ADC_I2S_CLK/WS/DATA : external bit clock, word select, serial data
//   SampleData/Valid    : registered head frame {left, right} and its valid
//   SampleReady         : pop head frame
//   Overflow            : sticky frame-dropped flag, cleared by OverflowClear
//
// state   | meaning
// SYNC    | waiting for a WS 1->0 boundary, nothing kept
// LEFT    | shifting left-channel bits
// RIGHT   | shifting right-channel bits, frame pushed at its end
module i2s_receiver
  import i2s_rx_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic                     ADC_I2S_CLK,
  input  logic                     ADC_I2S_WS,
  input  logic                     ADC_I2S_DATA,
  output logic [2*SAMPLE_BITS-1:0] SampleData,
  output logic                     SampleValid,
  input  logic                     SampleReady,
  output logic                     Overflow,
  input  logic                     OverflowClear
);

  localparam int unsigned CW = $clog2(SAMPLE_BITS + 1);
  localparam logic [SAMPLE_BITS-1:0] MSB_MASK = {1'b1, {(SAMPLE_BITS - 1){1'b0}}};

  logic [2:0]               sck_q;
  logic [1:0]               ws_sync_q;
  logic [1:0]               sd_sync_q;
  logic                     bit_evt, ws_s, sd_s, boundary;
  rx_state_e                state_q, state_d;
  logic                     ws_prev_q, ws_prev_d;
  logic [SAMPLE_BITS-1:0]   shreg_q, shreg_d, shreg_bit;
  logic [SAMPLE_BITS-1:0]   left_q, left_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [2*SAMPLE_BITS-1:0] frame_q, frame_d;
  logic                     push_q, push_d;

  // sck_q[2] is the edge-detect register behind the two synchronizer stages.
  assign bit_evt  = sck_q[1] & ~sck_q[2];
  assign ws_s     = ws_sync_q[1];
  assign sd_s     = sd_sync_q[1];
  assign boundary = (ws_s != ws_prev_q);

  // Bits beyond SAMPLE_BITS shift the mask out to zero, so they are dropped;
  // short channels keep their untouched zero LSBs.
  assign shreg_bit = shreg_q | ({SAMPLE_BITS{sd_s}} & (MSB_MASK >> cnt_q));
  assign cnt_inc   = (cnt_q == CW'(SAMPLE_BITS)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ws_prev_d = ws_prev_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    frame_d   = frame_q;
    push_d    = 1'b0;
    if (bit_evt) begin
      ws_prev_d = ws_s;
      case (state_q)
        ST_SYNC: begin
          if (ws_prev_q && !ws_s) begin
            state_d = ST_LEFT;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end
        ST_LEFT: begin
          if (boundary) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (ws_s) begin
              left_d  = shreg_bit;
              state_d = ST_RIGHT;
            end else begin
              state_d = ST_SYNC;
            end
          end else begin
            shreg_d = shreg_bit;
            cnt_d   = cnt_inc;
          end
        end
        ST_RIGHT: begin
          if (boundary) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (!ws_s) begin
              frame_d[FRAME_LEFT_SLOT*SAMPLE_BITS +: SAMPLE_BITS]  = left_q;
              frame_d[FRAME_RIGHT_SLOT*SAMPLE_BITS +: SAMPLE_BITS] = shreg_bit;
              push_d  = 1'b1;
              state_d = ST_LEFT;
            end else begin
              state_d = ST_SYNC;
            end
          end else begin
            shreg_d = shreg_bit;
            cnt_d   = cnt_inc;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
    if (!Enable) begin
      state_d = ST_SYNC;
      push_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sck_q     <= '0;
      ws_sync_q <= '0;
      sd_sync_q <= '0;
      state_q   <= ST_SYNC;
      ws_prev_q <= 1'b0;
      shreg_q   <= '0;
      left_q    <= '0;
      cnt_q     <= '0;
      frame_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      sck_q     <= {sck_q[1:0], ADC_I2S_CLK};
      ws_sync_q <= {ws_sync_q[0], ADC_I2S_WS};
      sd_sync_q <= {sd_sync_q[0], ADC_I2S_DATA};
      state_q   <= state_d;
      ws_prev_q <= ws_prev_d;
      shreg_q   <= shreg_d;
      left_q    <= left_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      push_q    <= push_d;
    end
  end

  i2s_rx_fifo #(
    .DW    (2 * SAMPLE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (Reset),
    .flush_i     (~Enable),
    .push_i      (push_q),
    .push_data_i (frame_q),
    .pop_i       (SampleReady),
    .ovf_clr_i   (OverflowClear),
    .data_o      (SampleData),
    .valid_o     (SampleValid),
    .overflow_o  (Overflow)
  );

endmodule
